// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, mode encodings
// and the default source count (matches the core's INT width).
package int_ctrl_pkg;

    localparam int unsigned NUM_SRC_DEFAULT = 5;

    typedef enum logic [1:0] {
        REG_STATUS = 2'd0,
        REG_MASK   = 2'd1,
        REG_CLEAR  = 2'd2,
        REG_MODE   = 2'd3
    } reg_addr_e;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser for an asynchronous input, async active-low reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller feeding the core's INT input: synchronises requests, latches
// pending per source (edge or level), masks, and exposes a word-addressed register port.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = NUM_SRC_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               we,
    input  logic [1:0]         a,
    input  logic [31:0]        d,
    output logic [31:0]        q,
    output logic [NUM_SRC-1:0] INT
);

    logic [NUM_SRC-1:0] w_s;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] r_s_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_int;
    logic               w_wr_mask;
    logic               w_wr_mode;
    logic               w_wr_clear;
    logic               w_unused_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        sync_ff #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_d     (irq_in[g]),
            .o_q     (w_s[g])
        );
    end

    // Register fields are only NUM_SRC wide; the rest of the write bus is ignored.
    assign w_unused_d = ^d[31:NUM_SRC];

    assign w_wr_mask  = we && (a == REG_MASK);
    assign w_wr_mode  = we && (a == REG_MODE);
    assign w_wr_clear = we && (a == REG_CLEAR);
    assign w_clr      = w_wr_clear ? d[NUM_SRC-1:0] : '0;

    always_comb begin
        w_set = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_mode[i] == MODE_EDGE) begin
                w_set[i] = w_s[i] & ~r_s_prev[i];
            end else begin
                w_set[i] = w_s[i];
            end
        end
    end

    // Set has priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_prev  <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_mode    <= '0;
            r_int     <= '0;
        end else begin
            r_s_prev  <= w_s;
            r_pending <= w_set | (r_pending & ~w_clr);
            r_int     <= r_pending & r_mask;
            if (w_wr_mask) begin
                r_mask <= d[NUM_SRC-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= d[NUM_SRC-1:0];
            end
        end
    end

    always_comb begin
        q = '0;
        unique case (a)
            REG_STATUS: q[NUM_SRC-1:0] = r_pending;
            REG_MASK:   q[NUM_SRC-1:0] = r_mask;
            REG_CLEAR:  q = '0;
            REG_MODE:   q[NUM_SRC-1:0] = r_mode;
            default:    q = '0;
        endcase
    end

    assign INT = r_int;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  irq_in;
    logic        we;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] q;
    logic [4:0]  int_o;

    int n_cmp;
    int n_bad;

    int_ctrl #(
        .NUM_SRC     (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .we     (we),
        .a      (a),
        .d      (d),
        .q      (q),
        .INT    (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: inputs applied before it, expectations hold after it.
    typedef struct {
        logic [4:0]  irq;
        logic        wr;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] eq;
        logic [4:0]  eint;
    } vec_t;

    vec_t tbl[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive at negedge, cross one posedge, return at the following negedge with we low.
    task automatic cyc(input logic [4:0] irq, input logic wr, input logic [1:0] wa,
                       input logic [31:0] wd);
        irq_in = irq;
        we     = wr;
        a      = wa;
        d      = wd;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        d  = '0;
    endtask

    task automatic rd(input logic [1:0] ra, input string name, input logic [31:0] exp);
        a = ra;
        #1;
        chk(name, q, exp);
    endtask

    task automatic chk_int(input string name, input logic [4:0] exp);
        chk(name, {27'd0, int_o}, {27'd0, exp});
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b0;
        irq_in = 5'h1F;
        we     = 1'b0;
        a      = 2'd0;
        d      = '0;

        tbl[0]  = '{5'h00, 1'b1, 2'd3, 32'h1F, 2'd3, 32'h1F, 5'h00};
        tbl[1]  = '{5'h00, 1'b1, 2'd1, 32'h01, 2'd1, 32'h01, 5'h00};
        tbl[2]  = '{5'h01, 1'b0, 2'd0, 32'h00, 2'd0, 32'h00, 5'h00};
        tbl[3]  = '{5'h01, 1'b0, 2'd0, 32'h00, 2'd0, 32'h00, 5'h00};
        tbl[4]  = '{5'h01, 1'b0, 2'd0, 32'h00, 2'd0, 32'h01, 5'h00};
        tbl[5]  = '{5'h01, 1'b0, 2'd0, 32'h00, 2'd0, 32'h01, 5'h01};
        tbl[6]  = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd0, 32'h01, 5'h01};
        tbl[7]  = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd0, 32'h01, 5'h01};
        tbl[8]  = '{5'h00, 1'b1, 2'd2, 32'h01, 2'd0, 32'h00, 5'h01};
        tbl[9]  = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd0, 32'h00, 5'h00};
        tbl[10] = '{5'h00, 1'b1, 2'd1, 32'h00, 2'd1, 32'h00, 5'h00};
        tbl[11] = '{5'h08, 1'b0, 2'd0, 32'h00, 2'd0, 32'h00, 5'h00};
        tbl[12] = '{5'h08, 1'b0, 2'd0, 32'h00, 2'd0, 32'h00, 5'h00};
        tbl[13] = '{5'h08, 1'b0, 2'd0, 32'h00, 2'd0, 32'h08, 5'h00};
        tbl[14] = '{5'h00, 1'b1, 2'd1, 32'h08, 2'd0, 32'h08, 5'h00};
        tbl[15] = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd1, 32'h08, 5'h08};
        tbl[16] = '{5'h00, 1'b1, 2'd2, 32'h08, 2'd0, 32'h00, 5'h08};
        tbl[17] = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd0, 32'h00, 5'h00};
        tbl[18] = '{5'h00, 1'b1, 2'd3, 32'h00, 2'd3, 32'h00, 5'h00};
        tbl[19] = '{5'h00, 1'b1, 2'd1, 32'h10, 2'd1, 32'h10, 5'h00};
        tbl[20] = '{5'h10, 1'b0, 2'd0, 32'h00, 2'd0, 32'h00, 5'h00};
        tbl[21] = '{5'h10, 1'b0, 2'd0, 32'h00, 2'd0, 32'h00, 5'h00};
        tbl[22] = '{5'h10, 1'b0, 2'd0, 32'h00, 2'd0, 32'h10, 5'h00};
        tbl[23] = '{5'h10, 1'b1, 2'd2, 32'h10, 2'd0, 32'h10, 5'h10};
        tbl[24] = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd0, 32'h10, 5'h10};
        tbl[25] = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd0, 32'h10, 5'h10};
        tbl[26] = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd0, 32'h10, 5'h10};
        tbl[27] = '{5'h00, 1'b1, 2'd2, 32'h10, 2'd0, 32'h00, 5'h10};
        tbl[28] = '{5'h00, 1'b0, 2'd0, 32'h00, 2'd2, 32'h00, 5'h00};
        tbl[29] = '{5'h00, 1'b1, 2'd0, 32'h1F, 2'd0, 32'h00, 5'h00};

        // Reset held with all requests high.
        repeat (3) @(negedge clk);
        chk_int("rst_int", 5'h00);
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], $sformatf("rst_q_a%0d", i), 32'h0);
        end

        // Release: default level mode latches the lines, but MASK=0 keeps INT low.
        @(negedge clk);
        rst = 1'b1;
        repeat (4) cyc(5'h1F, 1'b0, 2'd0, 32'h0);
        chk_int("post_rst_int", 5'h00);
        rd(2'd0, "post_rst_status", 32'h1F);
        repeat (3) cyc(5'h00, 1'b0, 2'd0, 32'h0);
        cyc(5'h00, 1'b1, 2'd2, 32'h1F);
        rd(2'd0, "post_rst_clear", 32'h0);

        for (int i = 0; i < 30; i++) begin
            cyc(tbl[i].irq, tbl[i].wr, tbl[i].wa, tbl[i].wd);
            rd(tbl[i].ra, $sformatf("vec%0d_q", i), tbl[i].eq);
            chk_int($sformatf("vec%0d_int", i), tbl[i].eint);
        end

        // Clear colliding with a fresh edge on src2: set must win.
        cyc(5'h00, 1'b1, 2'd3, 32'h1F);
        cyc(5'h00, 1'b1, 2'd1, 32'h04);
        repeat (3) cyc(5'h04, 1'b0, 2'd0, 32'h0);
        rd(2'd0, "col_pend", 32'h04);
        repeat (2) cyc(5'h00, 1'b0, 2'd0, 32'h0);
        repeat (2) cyc(5'h04, 1'b0, 2'd0, 32'h0);
        cyc(5'h04, 1'b1, 2'd2, 32'h04);
        rd(2'd0, "col_set_wins", 32'h04);
        chk_int("col_int", 5'h04);
        cyc(5'h04, 1'b1, 2'd2, 32'h04);
        rd(2'd0, "col_clean_clear", 32'h00);
        chk_int("col_int_lag", 5'h04);
        cyc(5'h04, 1'b0, 2'd0, 32'h0);
        rd(2'd0, "col_stays_clear", 32'h00);
        chk_int("col_int_drop", 5'h00);

        // Asynchronous reset between edges with every source active.
        repeat (2) cyc(5'h00, 1'b0, 2'd0, 32'h0);
        cyc(5'h00, 1'b1, 2'd1, 32'h1F);
        repeat (4) cyc(5'h1F, 1'b0, 2'd0, 32'h0);
        chk_int("pre_arst_int", 5'h1F);
        #2;
        rst = 1'b0;
        #1;
        chk_int("arst_int", 5'h00);
        @(negedge clk);
        irq_in = 5'h00;
        rst    = 1'b1;
        repeat (2) cyc(5'h00, 1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], $sformatf("arst_q_a%0d", i), 32'h0);
        end
        chk_int("arst_int_after", 5'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
